// File: rtl/our_multiplier_v2_if.sv
// AXI4-Lite 32-bit slave port bundle for the multiply/accumulate engine.
// The slave modport is the engine side; the master modport is the CPU/VIP side.
interface our_multiplier_v2_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/our_multiplier_v2.sv
// AXI4-Lite multiply / multiply-accumulate engine with a MUL_STAGES-deep product pipe.
// Optional level interrupt (irq = DONE & IRQ_EN) is built only when MULT_IRQ_EN is defined.
module our_multiplier_v2 #(
  parameter int OP_WIDTH   = 32,
  parameter int MUL_STAGES = 3,
  parameter int ACC_WIDTH  = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic               ACLK,
  input  logic               ARESET,
  our_multiplier_v2_if.slave s_axi
`ifdef MULT_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  logic                 r_awready, r_arready;
  logic                 r_bvalid, r_rvalid;
  logic [1:0]           r_bresp, r_rresp;
  logic [31:0]          r_rdata;
  logic [OP_WIDTH-1:0]  r_opa, r_opb;
  logic                 r_signed, r_accum;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done, r_err;
  logic [OP_WIDTH-1:0]  r_cap_a, r_cap_b;
  logic                 r_cap_signed, r_cap_accum;
  logic [ACC_WIDTH-1:0] r_result;
  logic [ACC_WIDTH-1:0] r_pipe [MUL_STAGES];

  logic                 w_wr_hs, w_rd_hs, w_wr_ok, w_rd_ok;
  logic [IDX_W-1:0]     w_wr_idx, w_rd_idx;
  logic                 w_ctrl_wr, w_start, w_clr, w_irq_en_rd;
  logic [31:0]          w_opa_cur, w_opb_cur, w_opa_merged, w_opb_merged;
  logic [31:0]          w_rd_data;
  logic [63:0]          w_res64;

  assign w_wr_hs   = r_awready & s_axi.AWVALID & s_axi.WVALID;
  assign w_rd_hs   = r_arready & s_axi.ARVALID;
  assign w_wr_idx  = s_axi.AWADDR[ADDR_WIDTH-1:2];
  assign w_rd_idx  = s_axi.ARADDR[ADDR_WIDTH-1:2];
  assign w_wr_ok   = (w_wr_idx < IDX_W'(3));
  assign w_rd_ok   = (w_rd_idx < IDX_W'(6));
  assign w_ctrl_wr = w_wr_hs & (w_wr_idx == IDX_W'(2)) & s_axi.WSTRB[0];
  assign w_start   = w_ctrl_wr & s_axi.WDATA[0];
  assign w_clr     = w_ctrl_wr & s_axi.WDATA[3];

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_awready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = r_arready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RRESP   = r_rresp;
  assign s_axi.RDATA   = r_rdata;

  // Byte-lane merge so partial writes keep the untouched operand bytes.
  assign w_opa_cur = 32'(r_opa);
  assign w_opb_cur = 32'(r_opb);
  for (genvar gi = 0; gi < 4; gi++) begin : g_strb
    assign w_opa_merged[8*gi +: 8] = s_axi.WSTRB[gi] ? s_axi.WDATA[8*gi +: 8] : w_opa_cur[8*gi +: 8];
    assign w_opb_merged[8*gi +: 8] = s_axi.WSTRB[gi] ? s_axi.WDATA[8*gi +: 8] : w_opb_cur[8*gi +: 8];
  end

`ifdef MULT_IRQ_EN
  logic r_irq_en;
  assign w_irq_en_rd = r_irq_en;
  assign irq         = r_done & r_irq_en;
`else
  assign w_irq_en_rd = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_opa     <= '0;
      r_opb     <= '0;
      r_signed  <= 1'b0;
      r_accum   <= 1'b0;
`ifdef MULT_IRQ_EN
      r_irq_en  <= 1'b0;
`endif
    end else begin
      // Ready is a single-cycle pulse; no new write is taken while a response is pending.
      r_awready <= s_axi.AWVALID & s_axi.WVALID & ~r_bvalid & ~r_awready;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
      end else if (s_axi.BREADY) begin
        r_bvalid <= 1'b0;
      end
      if (w_wr_hs && w_wr_idx == IDX_W'(0)) r_opa <= w_opa_merged[OP_WIDTH-1:0];
      if (w_wr_hs && w_wr_idx == IDX_W'(1)) r_opb <= w_opb_merged[OP_WIDTH-1:0];
      if (w_ctrl_wr) begin
        r_signed <= s_axi.WDATA[1];
        r_accum  <= s_axi.WDATA[2];
`ifdef MULT_IRQ_EN
        r_irq_en <= s_axi.WDATA[4];
`endif
      end
    end
  end

  assign w_res64 = 64'(r_result);

  always_comb begin
    w_rd_data = 32'd0;
    case (w_rd_idx)
      IDX_W'(0): w_rd_data = 32'(r_opa);
      IDX_W'(1): w_rd_data = 32'(r_opb);
      IDX_W'(2): w_rd_data = {27'd0, w_irq_en_rd, 1'b0, r_accum, r_signed, 1'b0};
      IDX_W'(3): w_rd_data = {29'd0, r_err, r_done, (r_state == ST_BUSY)};
      IDX_W'(4): w_rd_data = w_res64[31:0];
      IDX_W'(5): w_rd_data = w_res64[63:32];
      default:   w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= 32'd0;
    end else begin
      r_arready <= s_axi.ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
      end else if (s_axi.RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // One guard bit lets a single signed multiply serve both modes exactly.
  logic [OP_WIDTH:0]            w_a_ext, w_b_ext;
  logic signed [2*OP_WIDTH+1:0] w_a_sx, w_b_sx, w_prod_full;
  logic [ACC_WIDTH-1:0]         w_prod;

  assign w_a_ext     = {r_cap_signed & r_cap_a[OP_WIDTH-1], r_cap_a};
  assign w_b_ext     = {r_cap_signed & r_cap_b[OP_WIDTH-1], r_cap_b};
  assign w_a_sx      = (2*OP_WIDTH+2)'($signed(w_a_ext));
  assign w_b_sx      = (2*OP_WIDTH+2)'($signed(w_b_ext));
  assign w_prod_full = w_a_sx * w_b_sx;
  assign w_prod      = ACC_WIDTH'(w_prod_full);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < MUL_STAGES; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < MUL_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cap_a      <= '0;
      r_cap_b      <= '0;
      r_cap_signed <= 1'b0;
      r_cap_accum  <= 1'b0;
      r_result     <= '0;
    end else begin
      case (r_state)
        ST_BUSY: begin
          if (w_start) r_err <= 1'b1;
          if (r_cnt == CNT_W'(MUL_STAGES)) begin
            r_result <= r_cap_accum ? (r_result + r_pipe[MUL_STAGES-1]) : r_pipe[MUL_STAGES-1];
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          // DONE accepts a new START directly, giving MUL_STAGES+2 cycle throughput.
          if (w_start) begin
            r_cap_a      <= r_opa;
            r_cap_b      <= r_opb;
            r_cap_signed <= s_axi.WDATA[1];
            r_cap_accum  <= s_axi.WDATA[2];
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_state      <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
      if (w_clr) r_result <= '0;
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0], w_prod_full};

endmodule

// File: tb/tb_our_multiplier_v2.sv
// Scoreboard bench for our_multiplier_v2: expected responses are queued at issue
// and compared when the DUT returns them; irq checks build with MULT_IRQ_EN.
module tb_our_multiplier_v2;

  localparam int M = 3;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  our_multiplier_v2_if #(.ADDR_WIDTH(5)) axi();
`ifdef MULT_IRQ_EN
  logic irq;
`endif

  our_multiplier_v2 #(
    .OP_WIDTH(32), .MUL_STAGES(M), .ACC_WIDTH(64), .ADDR_WIDTH(5)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .s_axi(axi)
`ifdef MULT_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        rd_q[$];
  exp_t        wr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] acc_model = 64'd0;
  logic [31:0] m_opa = 32'd0;
  logic [31:0] m_opb = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic aw_issue(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, input string tag);
    bit hs = 0;
    wr_q.push_back('{tag, data, resp});
    axi.AWADDR = addr; axi.WDATA = data; axi.WSTRB = strb;
    axi.AWVALID = 1'b1; axi.WVALID = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      if (axi.AWREADY && axi.WREADY) hs = 1;
      @(posedge clk);
    end
    #1;
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
    check({tag, "_awhs"}, 64'(hs), 64'd1);
  endtask

  task automatic b_collect();
    bit seen = 0;
    logic [1:0] resp = 2'b00;
    exp_t e;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (axi.BVALID && axi.BREADY) begin
        seen = 1;
        resp = axi.BRESP;
      end
      @(posedge clk);
    end
    #1;
    if (wr_q.size() == 0) begin
      check("wr_queue_empty", 64'(seen), 64'd0);
      return;
    end
    e = wr_q.pop_front();
    $display("WR %s data=0x%08h bresp=%0d", e.tag, e.data, resp);
    check({e.tag, "_bvalid"}, 64'(seen), 64'd1);
    check({e.tag, "_bresp"}, 64'(resp), 64'(e.resp));
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input string tag);
    aw_issue(addr, data, strb, resp, tag);
    b_collect();
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input string tag);
    bit hs = 0;
    bit seen = 0;
    logic [31:0] got_d = 32'd0;
    logic [1:0]  got_r = 2'b00;
    exp_t e;
    rd_q.push_back('{tag, data, resp});
    axi.ARADDR = addr; axi.ARVALID = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      if (axi.ARREADY) hs = 1;
      @(posedge clk);
    end
    #1;
    axi.ARVALID = 1'b0;
    for (int c = 0; c < 50 && hs && !seen; c++) begin
      @(negedge clk);
      if (axi.RVALID && axi.RREADY) begin
        seen = 1;
        got_d = axi.RDATA;
        got_r = axi.RRESP;
      end
      @(posedge clk);
    end
    #1;
    e = rd_q.pop_front();
    $display("RD %s addr=0x%02h data=0x%08h rresp=%0d", e.tag, addr, got_d, got_r);
    check({e.tag, "_rvalid"}, 64'(seen), 64'd1);
    check({e.tag, "_rdata"}, 64'(got_d), 64'(e.data));
    check({e.tag, "_rresp"}, 64'(got_r), 64'(e.resp));
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    axi_write(5'h00, a, 4'hF, OKAY, "opa");
    axi_write(5'h04, b, 4'hF, OKAY, "opb");
    m_opa = a;
    m_opb = b;
  endtask

  // Writes CTRL with START set and advances the accumulator model.
  task automatic op_start(input logic [31:0] ctrl, input string tag);
    logic [63:0] p;
    axi_write(5'h08, ctrl, 4'hF, OKAY, tag);
    p = mul_model(m_opa, m_opb, ctrl[1]);
    if (ctrl[3]) acc_model = 64'd0;
    acc_model = ctrl[2] ? acc_model + p : p;
  endtask

  task automatic check_result(input string tag);
    axi_read(5'h10, acc_model[31:0], OKAY, {tag, "_lo"});
    axi_read(5'h14, acc_model[63:32], OKAY, {tag, "_hi"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bp_ok;
    axi.AWADDR = '0; axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0;
    axi.BREADY = 1'b1; axi.ARADDR = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_valid", 64'({axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID}), 64'd0);
    check("rst_data_resp", 64'({axi.RDATA, axi.RRESP, axi.BRESP}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) axi_read(5'(i * 4), 32'd0, OKAY, $sformatf("rst_reg%0d", i));
    axi_read(5'h18, 32'd0, SLVERR, "unmapped_rd");

    // Unsigned: STATUS sampled at the last BUSY edge, then at completion.
    set_ops(32'hFFFF_FFFF, 32'h2);
    op_start(32'h1, "start_u");
    repeat (M - 2) @(posedge clk);
    #1;
    axi_read(5'h0C, 32'h1, OKAY, "status_last_busy");
    axi_read(5'h0C, 32'h2, OKAY, "status_done_u");
    check_result("res_u");
    axi_read(5'h00, 32'hFFFF_FFFF, OKAY, "opa_rb");

    // Signed: first STATUS read that can see DONE must see it.
    set_ops(32'hFFFF_FFFD, 32'h7);
    op_start(32'h3, "start_s");
    repeat (M - 1) @(posedge clk);
    #1;
    axi_read(5'h0C, 32'h2, OKAY, "status_first_done");
    check_result("res_s");
    axi_read(5'h08, 32'h2, OKAY, "ctrl_signed_rb");

    // Accumulate: clear, 5*6 then 7*8.
    axi_write(5'h08, 32'h8, 4'hF, OKAY, "clr_acc");
    acc_model = 64'd0;
    check_result("res_cleared");
    set_ops(32'd5, 32'd6);
    op_start(32'h5, "start_acc1");
    repeat (M + 2) @(posedge clk);
    #1;
    set_ops(32'd7, 32'd8);
    op_start(32'h5, "start_acc2");
    axi_read(5'h10, 32'd30, OKAY, "res_during_busy");
    repeat (M + 2) @(posedge clk);
    #1;
    check_result("res_acc");
    axi_read(5'h08, 32'h4, OKAY, "ctrl_accum_rb");

    // CLR_ACC together with ACCUM|START accumulates onto zero.
    op_start(32'hD, "clr_start");
    repeat (M + 2) @(posedge clk);
    #1;
    check_result("res_clr_start");

    // START while BUSY is ignored and flags ERR.
    set_ops(32'd3, 32'd4);
    op_start(32'h1, "start_e");
    axi_write(5'h08, 32'h1, 4'hF, OKAY, "start_busy");
    repeat (M + 2) @(posedge clk);
    #1;
    axi_read(5'h0C, 32'h6, OKAY, "status_err");
    check_result("res_err");

    // Operand rewrite during BUSY leaves the in-flight op alone.
    op_start(32'h1, "start_rw");
    axi_write(5'h00, 32'd100, 4'hF, OKAY, "opa_busy");
    m_opa = 32'd100;
    repeat (M + 2) @(posedge clk);
    #1;
    check_result("res_rw");
    axi_read(5'h0C, 32'h2, OKAY, "status_err_cleared");

    // Error responses and byte strobes.
    axi_write(5'h0C, 32'hFFFF, 4'hF, SLVERR, "wr_status");
    axi_write(5'h10, 32'hFFFF, 4'hF, SLVERR, "wr_res_lo");
    axi_write(5'h18, 32'hFFFF, 4'hF, SLVERR, "wr_unmapped");
    axi_read(5'h0C, 32'h2, OKAY, "status_after_slverr");
    check_result("res_after_slverr");
    axi_write(5'h00, 32'hAABB_CCDD, 4'b0101, OKAY, "opa_strb");
    axi_read(5'h00, 32'h00BB_00DD, OKAY, "opa_strb_rb");
    axi_write(5'h08, 32'h1, 4'b1110, OKAY, "ctrl_nobyte0");
    repeat (M + 2) @(posedge clk);
    #1;
    axi_read(5'h0C, 32'h2, OKAY, "status_no_start");

    // BREADY low: BVALID holds and the next write waits.
    axi.BREADY = 1'b0;
    aw_issue(5'h00, 32'h11, 4'hF, OKAY, "bp_opa");
    axi.AWADDR = 5'h04; axi.WDATA = 32'h22; axi.WSTRB = 4'hF;
    axi.AWVALID = 1'b1; axi.WVALID = 1'b1;
    bp_ok = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!axi.BVALID || axi.AWREADY) bp_ok = 0;
    end
    check("bp_hold", 64'(bp_ok), 64'd1);
    @(posedge clk);
    #1;
    axi.BREADY = 1'b1;
    b_collect();
    axi_write(5'h04, 32'h22, 4'hF, OKAY, "bp_opb");
    axi_read(5'h00, 32'h11, OKAY, "bp_opa_rb");
    axi_read(5'h04, 32'h22, OKAY, "bp_opb_rb");
    m_opa = 32'h11;
    m_opb = 32'h22;

`ifdef MULT_IRQ_EN
    op_start(32'h11, "irq_start1");
    check("irq_busy", 64'(irq), 64'd0);
    repeat (M + 2) @(posedge clk);
    #1;
    check("irq_done", 64'(irq), 64'd1);
    axi_read(5'h08, 32'h10, OKAY, "ctrl_irqen_rb");
    op_start(32'h11, "irq_start2");
    check("irq_cleared_start", 64'(irq), 64'd0);
    repeat (M + 2) @(posedge clk);
    #1;
    check("irq_done2", 64'(irq), 64'd1);
    axi_write(5'h08, 32'h0, 4'hF, OKAY, "irq_en_off");
    check("irq_cleared_en", 64'(irq), 64'd0);
`else
    axi_write(5'h08, 32'h10, 4'hF, OKAY, "ctrl_irqen");
    axi_read(5'h08, 32'h0, OKAY, "ctrl_irqen_absent");
`endif

    // Reset in the middle of an operation.
    set_ops(32'd3, 32'd4);
    op_start(32'h1, "start_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_model = 64'd0;
    axi_read(5'h0C, 32'h0, OKAY, "status_after_rst");
    check_result("res_after_rst");
    repeat (M + 3) @(posedge clk);
    #1;
    axi_read(5'h0C, 32'h0, OKAY, "status_no_done");
    axi_read(5'h00, 32'h0, OKAY, "opa_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
